// File: rtl/cdb_pkg.sv
// cdb_pkg: shared types and constants for the CDB write-back arbiter.
//   cdb_pkt_t    : one completion packet {value, tag, excp, cause}
//   cdb_cause_e  : exception cause codes carried with a result
//   U_ALU..U_CSR : execution unit indices (request/slot position)
//   wrap_add     : small helper reducing a sum below a modulus (a < 2*n)
package cdb_pkg;

    localparam int CDB_NREQ = 6;
    localparam int CDB_DW   = 32;
    localparam int CDB_TAGW = 32;

    typedef struct packed {
        logic [CDB_DW-1:0]   value;
        logic [CDB_TAGW-1:0] tag;
        logic                excp;
        logic [1:0]          cause;
    } cdb_pkt_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_DIV0 = 2'b01,
        CAUSE_LS   = 2'b10,
        CAUSE_ADDR = 2'b11
    } cdb_cause_e;

    localparam int U_ALU = 0;
    localparam int U_MUL = 1;
    localparam int U_DIV = 2;
    localparam int U_BR  = 3;
    localparam int U_LSU = 4;
    localparam int U_CSR = 5;

    function automatic int wrap_add(input int a, input int n);
        return (a >= n) ? (a - n) : a;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational NREQ-way rotate-priority picker.
// The search starts at ptr and walks upward cyclically; the first set
// request wins. Tie ptr to zero for plain lowest-index-first priority.
//   req   in  NREQ  request vector
//   ptr   in  IW    index with highest priority this cycle (must be < NREQ)
//   grant out NREQ  one-hot grant (all zero when no request)
//   idx   out IW    index of the granted request
//   any   out 1     at least one request present
module rr_arbiter
    import cdb_pkg::*;
#(
    parameter int NREQ = 6,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] sel;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sel = IW'(wrap_add(int'(ptr) + k, NREQ));
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

    assign any = found;

endmodule

// File: rtl/cdb_wb_arbiter.sv
// cdb_wb_arbiter: shares the single ROB completion (CDB) port among the
// execution units (0=ALU 1=MUL 2=DIV 3=BR 4=LSU 5=CSR). Each unit owns a
// one-entry holding slot; one slot per cycle is forwarded as a registered
// CDB beat.
// Build option: define CDB_FIXED_PRIO_EN for fixed lowest-index-first
// priority (no rotating pointer, no fairness). Default is round-robin.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     drop all pending results, refuse new ones
//   cdb_stall                 ROB cannot take a beat this cycle
//   req_valid/ready           per-unit handshake (ready is combinational)
//   req_value/tag/excp/cause  packed per-unit result fields
//   cdb_valid/value/tag/excp/cause/src  registered CDB beat
module cdb_wb_arbiter
    import cdb_pkg::*;
#(
    parameter int NREQ = 6,
    parameter int DW   = 32,
    parameter int TAGW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 cdb_stall,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_value,
    input  logic [NREQ*TAGW-1:0] req_tag,
    input  logic [NREQ-1:0]      req_excp,
    input  logic [NREQ*2-1:0]    req_cause,
    output logic                 cdb_valid,
    output logic [DW-1:0]        cdb_value,
    output logic [TAGW-1:0]      cdb_tag,
    output logic                 cdb_excp,
    output logic [1:0]           cdb_cause,
    output logic [2:0]           cdb_src
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] slot_v;
    logic [DW-1:0]   slot_value [NREQ];
    logic [TAGW-1:0] slot_tag   [NREQ];
    logic            slot_excp  [NREQ];
    logic [1:0]      slot_cause [NREQ];

    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [IW-1:0]   arb_ptr;
    logic [NREQ-1:0] load;

    // Stall and flush mask the requests so the picker never grants in those
    // cycles; this keeps grant a pure function of slot occupancy otherwise.
    assign arb_req   = slot_v & {NREQ{~cdb_stall & ~flush}};
    // A slot being granted this cycle is free to take a new result on the
    // same edge, so a continuously requesting unit loses no cycles.
    assign req_ready = {NREQ{~flush}} & (~slot_v | gnt);
    assign load      = req_valid & req_ready;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr_arbiter (
        .req   (arb_req),
        .ptr   (arb_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

`ifdef CDB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [IW-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= IW'(wrap_add(int'(gnt_idx) + 1, NREQ));
        end
    end

    assign arb_ptr = rr_ptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v    <= '0;
            cdb_valid <= 1'b0;
            cdb_value <= '0;
            cdb_tag   <= '0;
            cdb_excp  <= 1'b0;
            cdb_cause <= '0;
            cdb_src   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                slot_value[i] <= '0;
                slot_tag[i]   <= '0;
                slot_excp[i]  <= 1'b0;
                slot_cause[i] <= '0;
            end
        end else begin
            cdb_valid <= 1'b0;
            if (flush) begin
                slot_v <= '0;
            end else begin
                if (gnt_any) begin
                    cdb_valid <= 1'b1;
                    cdb_value <= slot_value[gnt_idx];
                    cdb_tag   <= slot_tag[gnt_idx];
                    cdb_excp  <= slot_excp[gnt_idx];
                    cdb_cause <= slot_cause[gnt_idx];
                    cdb_src   <= 3'(gnt_idx);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (load[i]) begin
                        slot_v[i]     <= 1'b1;
                        slot_value[i] <= req_value[i*DW +: DW];
                        slot_tag[i]   <= req_tag[i*TAGW +: TAGW];
                        slot_excp[i]  <= req_excp[i];
                        slot_cause[i] <= req_cause[i*2 +: 2];
                    end else if (gnt[i]) begin
                        slot_v[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// tb_cdb_wb_arbiter: self-checking bench for cdb_wb_arbiter.
// Expected beats are queued when stimulus is driven; a negedge monitor pops
// and compares every CDB beat. Directed checks cover reset, latency, stall,
// flush and reset-during-stall. Define CDB_FIXED_PRIO_EN for the
// fixed-priority build.
module tb_cdb_wb_arbiter;
    import cdb_pkg::*;

    localparam int NREQ = 6;
    localparam int DW   = 32;
    localparam int TAGW = 32;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic                 cdb_stall;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_value;
    logic [NREQ*TAGW-1:0] req_tag;
    logic [NREQ-1:0]      req_excp;
    logic [NREQ*2-1:0]    req_cause;
    logic                 cdb_valid;
    logic [DW-1:0]        cdb_value;
    logic [TAGW-1:0]      cdb_tag;
    logic                 cdb_excp;
    logic [1:0]           cdb_cause;
    logic [2:0]           cdb_src;

    typedef struct {
        logic [DW-1:0]   value;
        logic [TAGW-1:0] tag;
        logic            excp;
        logic [1:0]      cause;
        logic [2:0]      src;
    } beat_t;

    beat_t sb[$];
    int    n_chk = 0;
    int    n_err = 0;
    int    rdy_cnt [NREQ];

    cdb_wb_arbiter #(.NREQ(NREQ), .DW(DW), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .cdb_stall (cdb_stall),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_value (req_value),
        .req_tag   (req_tag),
        .req_excp  (req_excp),
        .req_cause (req_cause),
        .cdb_valid (cdb_valid),
        .cdb_value (cdb_value),
        .cdb_tag   (cdb_tag),
        .cdb_excp  (cdb_excp),
        .cdb_cause (cdb_cause),
        .cdb_src   (cdb_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Beat monitor: outputs are registered, so the falling edge sees them settled.
    always @(negedge clk) begin
        if (!rst && cdb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", cdb_valid, 1'b0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_value", cdb_value, e.value);
                chk("beat_tag",   cdb_tag,   e.tag);
                chk("beat_excp",  cdb_excp,  e.excp);
                chk("beat_cause", cdb_cause, e.cause);
                chk("beat_src",   cdb_src,   e.src);
            end
        end
    end

    function automatic logic [31:0] val_of(input int u, input int k);
        return 32'hA000_0000 | (u << 8) | k;
    endfunction

    function automatic logic [31:0] tag_of(input int u, input int k);
        return 32'h7000_0000 | (u << 8) | k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int u, input logic [31:0] v, input logic [31:0] t,
                            input logic e, input logic [1:0] c);
        req_valid[u]           = 1'b1;
        req_value[u*DW +: DW]  = v;
        req_tag[u*TAGW +: TAGW] = t;
        req_excp[u]            = e;
        req_cause[u*2 +: 2]    = c;
    endtask

    task automatic push(input logic [31:0] v, input logic [31:0] t,
                        input logic e, input logic [1:0] c, input int s);
        beat_t b;
        b.value = v;
        b.tag   = t;
        b.excp  = e;
        b.cause = c;
        b.src   = 3'(s);
        sb.push_back(b);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        cdb_stall = 1'b0;
        req_valid = '0;
        req_value = '0;
        req_tag   = '0;
        req_excp  = '0;
        req_cause = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) tick();
        tick();
        tick();
        chk(tag, sb.size(), 0);
    endtask

    // Present a stream from every unit in mask for ncyc edges; each unit
    // offers its next numbered result once the previous one was accepted.
    task automatic stream(input logic [NREQ-1:0] mask, input int ncyc);
        int nacc [NREQ];
        logic [NREQ-1:0] rdy;
        for (int i = 0; i < NREQ; i++) begin
            nacc[i]    = 0;
            rdy_cnt[i] = 0;
        end
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (mask[i]) set_unit(i, val_of(i, nacc[i]), tag_of(i, nacc[i]), 1'b0, CAUSE_NONE);
            #2;
            rdy = req_ready;
            if (c >= 1 && c <= NREQ)
                for (int i = 0; i < NREQ; i++) if (rdy[i]) rdy_cnt[i]++;
            tick();
            for (int i = 0; i < NREQ; i++) if (mask[i] && rdy[i]) nacc[i]++;
        end
        req_valid = '0;
    endtask

    initial begin
        #1;
        // T1: reset values, single ALU result and its latency
        do_reset();
        chk("rst_valid", cdb_valid, 1'b0);
        chk("rst_value", cdb_value, 32'h0);
        chk("rst_tag",   cdb_tag,   32'h0);
        chk("rst_src",   cdb_src,   3'd0);
        chk("rst_ready", req_ready, 6'h3f);
        set_unit(U_ALU, 32'h1234, 32'h40, 1'b0, CAUSE_NONE);
        push(32'h1234, 32'h40, 1'b0, CAUSE_NONE, U_ALU);
        tick();
        req_valid = '0;
        chk("lat_e0_valid", cdb_valid, 1'b0);
        tick();
        chk("lat_e1_valid", cdb_valid, 1'b1);
        drain("t1_drain", 10);

`ifndef CDB_FIXED_PRIO_EN
        // T2: all units continuously valid -> strict rotation 0..5
        do_reset();
        for (int j = 0; j < 3 * NREQ; j++)
            push(val_of(j % NREQ, j / NREQ), tag_of(j % NREQ, j / NREQ), 1'b0, CAUSE_NONE, j % NREQ);
        stream(6'h3f, 2 * NREQ + 1);
        for (int i = 0; i < NREQ; i++) chk($sformatf("t2_ready_once_u%0d", i), rdy_cnt[i], 1);
        drain("t2_drain", 40);
`endif

        // T3: MUL and DIV(exception) held off by a 3-cycle stall
        do_reset();
        set_unit(U_MUL, 32'h11, 32'h10, 1'b0, CAUSE_NONE);
        set_unit(U_DIV, 32'hD1, 32'hD0, 1'b1, CAUSE_DIV0);
        push(32'h11, 32'h10, 1'b0, CAUSE_NONE, U_MUL);
        push(32'hD1, 32'hD0, 1'b1, CAUSE_DIV0, U_DIV);
        tick();
        req_valid = '0;
        cdb_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t3_stall_valid", cdb_valid, 1'b0);
            chk("t3_stall_ready", req_ready[2:1], 2'b00);
        end
        cdb_stall = 1'b0;
        tick();
        chk("t3_first_beat", cdb_valid, 1'b1);
        drain("t3_drain", 10);

        // T4: flush drops a pending LSU result and refuses new requests
        do_reset();
        set_unit(U_LSU, 32'h4444, 32'h4444, 1'b0, CAUSE_NONE);
        tick();
        req_valid = '0;
        flush     = 1'b1;
        set_unit(U_ALU, 32'h9999, 32'h9999, 1'b0, CAUSE_NONE);
        #1;
        chk("t4_flush_ready", req_ready, 6'h00);
        tick();
        flush     = 1'b0;
        req_valid = '0;
        #1;
        chk("t4_post_valid", cdb_valid, 1'b0);
        chk("t4_post_ready", req_ready, 6'h3f);
        for (int c = 0; c < 5; c++) tick();
        drain("t4_drain", 2);

        // T5: reset while stalled with three full slots
        do_reset();
        set_unit(U_DIV, 32'h2222, 32'h2020, 1'b1, CAUSE_ADDR);
        push(32'h2222, 32'h2020, 1'b1, CAUSE_ADDR, U_DIV);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t5_sb_pre", sb.size(), 0);
        cdb_stall = 1'b1;
        set_unit(U_MUL, 32'hB1, 32'hB1, 1'b0, CAUSE_NONE);
        set_unit(U_BR,  32'hB3, 32'hB3, 1'b0, CAUSE_NONE);
        set_unit(U_CSR, 32'hB5, 32'hB5, 1'b0, CAUSE_NONE);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        cdb_stall = 1'b0;
        #1;
        chk("t5_rst_valid", cdb_valid, 1'b0);
        chk("t5_rst_value", cdb_value, 32'h0);
        chk("t5_rst_tag",   cdb_tag,   32'h0);
        chk("t5_rst_excp",  cdb_excp,  1'b0);
        chk("t5_rst_cause", cdb_cause, 2'b00);
        chk("t5_rst_src",   cdb_src,   3'd0);
        chk("t5_rst_ready", req_ready, 6'h3f);
        set_unit(U_MUL, 32'hC1, 32'hC1, 1'b0, CAUSE_NONE);
        set_unit(U_BR,  32'hC3, 32'hC3, 1'b0, CAUSE_NONE);
        set_unit(U_CSR, 32'hC5, 32'hC5, 1'b0, CAUSE_NONE);
`ifdef CDB_FIXED_PRIO_EN
        push(32'hC1, 32'hC1, 1'b0, CAUSE_NONE, U_MUL);
        push(32'hC3, 32'hC3, 1'b0, CAUSE_NONE, U_BR);
        push(32'hC5, 32'hC5, 1'b0, CAUSE_NONE, U_CSR);
`else
        push(32'hC1, 32'hC1, 1'b0, CAUSE_NONE, U_MUL);
        push(32'hC3, 32'hC3, 1'b0, CAUSE_NONE, U_BR);
        push(32'hC5, 32'hC5, 1'b0, CAUSE_NONE, U_CSR);
`endif
        tick();
        req_valid = '0;
        drain("t5_drain", 10);

`ifdef CDB_FIXED_PRIO_EN
        // T6: ALU and CSR both continuous -> ALU every cycle, CSR only afterwards
        do_reset();
        for (int k = 0; k < 9; k++) push(val_of(U_ALU, k), tag_of(U_ALU, k), 1'b0, CAUSE_NONE, U_ALU);
        push(val_of(U_CSR, 0), tag_of(U_CSR, 0), 1'b0, CAUSE_NONE, U_CSR);
        stream(6'b100001, 9);
        drain("t6_drain", 20);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
